// File: rtl/mpc_dot_pkg.sv
// ---------------------------------------------------------------------------
// mpc_dot_pkg : shared types, default widths and saturation helper for mpc_dot_acc.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mpc_dot_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    SCALE = 2'd1,
    HOLD  = 2'd2
  } dot_state_t;

  localparam int DOT_DIN_WIDTH  = 35;
  localparam int DOT_ACC_WIDTH  = 42;
  localparam int DOT_DOUT_WIDTH = 21;
  localparam int DOT_FRAC_SHIFT = 12;
  localparam int DOT_MAX_TERMS  = 128;

  // Clamp a sign-extended value into the range of a width-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpc_dot_acc_scale.sv
// ---------------------------------------------------------------------------
// mpc_dot_acc_scale : combinational round / arithmetic shift / saturate of a row sum.
// Rounding add only when MPC_DOT_ACC_ROUND_EN is defined. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mpc_dot_acc_scale
  import mpc_dot_pkg::*;
#(
  parameter int ACC_WIDTH  = DOT_ACC_WIDTH,
  parameter int DOUT_WIDTH = DOT_DOUT_WIDTH,
  parameter int FRAC_SHIFT = DOT_FRAC_SHIFT
) (
  input  logic [ACC_WIDTH-1:0]  sum,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat
);

`ifdef MPC_DOT_ACC_ROUND_EN
  localparam logic [ACC_WIDTH:0] RND_INC = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
`else
  localparam logic [ACC_WIDTH:0] RND_INC = '0;
`endif

  logic signed [ACC_WIDTH:0] sum_ext;
  logic signed [ACC_WIDTH:0] rounded;
  logic signed [ACC_WIDTH:0] shifted;
  logic signed [63:0]        wide;
  logic signed [63:0]        clamped;

  // One guard bit keeps the rounding increment from wrapping a near-full sum.
  always_comb begin
    sum_ext = {sum[ACC_WIDTH-1], sum};
    rounded = sum_ext + $signed(RND_INC);
    shifted = rounded >>> FRAC_SHIFT;
    wide    = 64'(shifted);
    clamped = sat_signed(wide, DOUT_WIDTH);
    dout    = clamped[DOUT_WIDTH-1:0];
    sat     = (clamped != wide);
  end

endmodule

`default_nettype wire

// File: rtl/mpc_dot_acc.sv
// ---------------------------------------------------------------------------
// mpc_dot_acc : streaming dot-product accumulator with rescale/saturate per row.
// Optional round-half-up via MPC_DOT_ACC_ROUND_EN. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mpc_dot_acc
  import mpc_dot_pkg::*;
#(
  parameter int DIN_WIDTH  = DOT_DIN_WIDTH,
  parameter int ACC_WIDTH  = DOT_ACC_WIDTH,
  parameter int DOUT_WIDTH = DOT_DOUT_WIDTH,
  parameter int FRAC_SHIFT = DOT_FRAC_SHIFT,
  parameter int MAX_TERMS  = DOT_MAX_TERMS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_sat,
  output logic                  err_ovf
);

  localparam int                   CNT_WIDTH = $clog2(MAX_TERMS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_TERMS);

  dot_state_t            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [DOUT_WIDTH-1:0] res_q, res_d;
  logic                  res_sat_q, res_sat_d;
  logic [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                  out_sat_q, out_sat_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  live_q, live_d;

  logic                  in_fire;
  logic                  out_fire;
  logic [DOUT_WIDTH-1:0] scl_dout;
  logic                  scl_sat;

  mpc_dot_acc_scale #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_scale (
    .sum  (acc_q),
    .dout (scl_dout),
    .sat  (scl_sat)
  );

  // live_q keeps in_ready low for the reset cycle itself.
  assign in_ready  = ce & live_q & (state_q == ACC);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready & ce;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_sat   = out_sat_q;
  assign err_ovf   = err_ovf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ce) begin
      case (state_q)
        ACC:     if (in_fire && in_last) state_d = SCALE;
        SCALE:   if (phase_q) state_d = HOLD;
        HOLD:    if (out_fire) state_d = ACC;
        default: state_d = ACC;
      endcase
    end
  end

  // SCALE spans two cycles: capture the scaler output, then present it.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    res_d       = res_q;
    res_sat_d   = res_sat_q;
    dout_d      = dout_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    err_ovf_d   = err_ovf_q;
    live_d      = live_q;
    if (ce) begin
      live_d = 1'b1;
      case (state_q)
        ACC: begin
          if (in_fire) begin
            acc_d = acc_q + {{(ACC_WIDTH - DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
            if (in_last) begin
              cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
              err_ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        SCALE: begin
          if (!phase_q) begin
            res_d     = scl_dout;
            res_sat_d = scl_sat;
            phase_d   = 1'b1;
          end else begin
            dout_d      = res_q;
            out_sat_d   = res_sat_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            phase_d     = 1'b0;
          end
        end
        HOLD: begin
          if (out_fire) out_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      res_q       <= '0;
      res_sat_q   <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      res_q       <= res_d;
      res_sat_q   <= res_sat_d;
      dout_q      <= dout_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      err_ovf_q   <= err_ovf_d;
      live_q      <= live_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mpc_dot_acc.sv
// ---------------------------------------------------------------------------
// tb_mpc_dot_acc : scoreboard bench for mpc_dot_acc against an arithmetic row model.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mpc_dot_acc;

  localparam int DW = 35;
  localparam int OW = 21;

  typedef struct {
    longint d;
    bit     s;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          in_last = 1'b0;
  logic          rnd_en = 1'b0;
  logic          ce_force = 1'b1;
  logic          or_force = 1'b1;
  logic          ce_rnd = 1'b1;
  logic          or_rnd = 1'b1;
  logic          ce;
  logic          out_ready;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] dout;
  logic          out_sat;
  logic          err_ovf;

  int     n_checks = 0;
  int     n_fail = 0;
  longint row_sum = 0;
  exp_t   exp_q[$];

  assign ce        = rnd_en ? ce_rnd : ce_force;
  assign out_ready = rnd_en ? or_rnd : or_force;

  mpc_dot_acc dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_sat   (out_sat),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got timeout expected event", name);
  endtask

  // Row result: floor((sum [+ half]) / 2^12), clamped to the 21-bit signed range.
  function automatic exp_t model(input longint s);
    exp_t   e;
    longint v;
    v = s;
`ifdef MPC_DOT_ACC_ROUND_EN
    v = v + 2048;
`endif
    v   = v >>> 12;
    e.s = 1'b0;
    if (v > 1048575) begin
      v   = 1048575;
      e.s = 1'b1;
    end else if (v < -1048576) begin
      v   = -1048576;
      e.s = 1'b1;
    end
    e.d = v;
    return e;
  endfunction

  task automatic send(input longint d, input bit last);
    int waited;
    bit done;
    bit taken;
    waited = 0;
    done   = 1'b0;
    taken  = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    din      = d[DW-1:0];
    in_last  = last;
    while (!done) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        done  = 1'b1;
        taken = 1'b1;
      end else begin
        waited++;
        if (waited > 300) begin
          fail_now("send_accept");
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (taken) begin
      row_sum += d;
      if (last) begin
        exp_q.push_back(model(row_sum));
        row_sum = 0;
      end
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now(name);
    @(negedge clk);
  endtask

  function automatic longint rand_din();
    longint v;
    if ($urandom_range(0, 3) == 0) begin
      v = longint'({$urandom, $urandom});
      v = (v <<< 29) >>> 29;
    end else begin
      v = longint'($urandom_range(0, 2000000)) - 1000000;
    end
    return v;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      ce_rnd = ($urandom_range(0, 3) != 0);
      or_rnd = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: pops on every output transfer and checks that a stalled result holds.
  initial begin
    bit            stalled;
    logic [OW-1:0] held;
    exp_t          e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", longint'(out_valid), 1);
          chk("hold_dout", longint'($signed(dout)), longint'($signed(held)));
        end
        if (out_valid && out_ready && ce) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got dout %0d expected no result", $signed(dout));
          end else begin
            e = exp_q.pop_front();
            chk("dout", longint'($signed(dout)), e.d);
            chk("out_sat", longint'(out_sat), longint'(e.s));
          end
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled = 1'b1;
          held    = dout;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_dout", longint'($signed(dout)), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    chk("rst_err_ovf", longint'(err_ovf), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;

    // single beat: latency and in_ready return
    send(409600, 1'b1);
    @(negedge clk); #1;
    chk("lat_edge1", longint'(out_valid), 0);
    @(negedge clk); #1;
    chk("lat_edge2_valid", longint'(out_valid), 0);
    chk("lat_edge2_ready", longint'(in_ready), 0);
    @(negedge clk); #1;
    chk("lat_valid", longint'(out_valid), 1);
    chk("lat_busy", longint'(in_ready), 0);
    @(negedge clk); #1;
    chk("lat_one_cycle", longint'(out_valid), 0);
    chk("lat_ready_back", longint'(in_ready), 1);

    // multi-beat, rounding and saturation rows
    send(2048, 1'b0);
    send(2048, 1'b0);
    send(4096, 1'b1);
    send(2048, 1'b1);
    send(-2048, 1'b1);
    send((longint'(1) << 34) - 1, 1'b1);
    send(-(longint'(1) << 34), 1'b1);
    wait_empty("drain_basic");

    // backpressure
    or_force = 1'b0;
    send(longint'(12345) * 4096, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!out_valid) fail_now("bp_valid");
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_in_ready", longint'(in_ready), 0);
    end
    or_force = 1'b1;
    @(negedge clk); #1;
    chk("bp_ready_back", longint'(in_ready), 1);
    chk("bp_valid_drop", longint'(out_valid), 0);

    // random rows with random ce and out_ready
    rnd_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) send(rand_din(), b == len - 1);
    end
    rnd_en = 1'b0;
    wait_empty("drain_random");

    // term overflow
    for (int i = 1; i <= 130; i++) begin
      send(1, i == 130);
      if (i == 128) chk("ovf_not_yet", longint'(err_ovf), 0);
      if (i == 129) chk("ovf_set", longint'(err_ovf), 1);
    end
    wait_empty("drain_ovf");
    chk("ovf_sticky", longint'(err_ovf), 1);

    // mid-row reset discards the partial sum
    send(4096, 1'b0);
    send(4096, 1'b0);
    send(4096, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    row_sum = 0;
    chk("rst2_out_valid", longint'(out_valid), 0);
    chk("rst2_dout", longint'($signed(dout)), 0);
    chk("rst2_out_sat", longint'(out_sat), 0);
    chk("rst2_err_ovf", longint'(err_ovf), 0);
    chk("rst2_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    send(8192, 1'b1);
    wait_empty("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mpc_dot_acc.md
# mpc_dot_acc

- Streaming dot-product accumulator for the implicit-MPC datapath. Sits directly downstream of the 4-stage `21s × 13ns → 35` signed multiplier.
- Accepts one product per cycle and sums the products of a row of terms.
- At the end of each row, rescales the sum by the weight fraction width and saturates it back to the 21-bit signed operand format.
- The result feeds the next solver iteration.

## Interface
- `DIN_WIDTH`, 35: signed product width from the multiplier.
- `ACC_WIDTH`, 42: signed accumulator width; must be ≥ DIN_WIDTH + clog2(MAX_TERMS).
- `DOUT_WIDTH`, 21: signed result width.
- `FRAC_SHIFT`, 12: right-shift applied to the final sum; ≥1.
- `MAX_TERMS`, 128: maximum number of beats per row.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `ce` in 1: clock enable. When low, all registers hold and no transfer occurs.
- `in_valid` in 1: product beat valid, aligned with `din`.
- `in_ready` out 1: block can accept a beat.
- `din` in DIN_WIDTH: signed product.
- `in_last` in 1: this beat is the final term of the row.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `dout` out DOUT_WIDTH: rounded, saturated signed result.
- `out_sat` out 1: `dout` was clamped. Qualified by `out_valid`.
- `err_ovf` out 1: sticky flag; a row exceeded MAX_TERMS.

## Operation
- Input transfer: `in_valid & in_ready & ce`. Output transfer: `out_valid & out_ready & ce`.
- FSM has three states.
  - ACC: `in_ready = ce`. On each input transfer, `acc ← acc + sext(din)` and `cnt ← cnt + 1`. A transfer with `in_last` moves to SCALE, registers the final sum (including that beat), and clears `cnt`.
  - SCALE: `in_ready = 0`. Rounds the final sum, shifts it arithmetically right by FRAC_SHIFT, and saturates it to [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1]. Loads `dout` and `out_sat`, sets `out_valid`, clears `acc`, and moves to HOLD.
  - HOLD: `in_ready = 0`. `dout`, `out_sat` and `out_valid` are stable until the output transfer. On that transfer, `out_valid ← 0` and the FSM moves to ACC.
- Single-beat rows (`in_last` on the first beat) are legal.
- Overflow: an input transfer without `in_last` while `cnt == MAX_TERMS` sets `err_ovf`. The beat is still accumulated. `err_ovf` clears only on reset.
- Arithmetic:
  - The accumulator wraps modulo 2^ACC_WIDTH. The width rule above guarantees no wrap within MAX_TERMS beats.
  - Rounding and shift are done in ACC_WIDTH+1 bits, so the rounding add cannot wrap.
- Reset:
  - FSM goes to ACC; `acc` and `cnt` are cleared.
  - Output values: `out_valid=0`, `dout=0`, `out_sat=0`, `err_ovf=0`, `in_ready=0`.
  - A reset mid-row discards the partial sum.
  - `in_ready` rises in the first cycle after reset deasserts, provided `ce=1`.

## Timing
- An input transfer with `in_last` at edge N produces `out_valid=1` after edge N+2. Latency is 2 cycles.
- When `out_ready=1` throughout, `out_valid` is high for exactly one cycle and `in_ready` returns after edge N+3.
- Minimum row period is `terms + 3` cycles.
- `out_ready` may be asserted before `out_valid`; no combinational path from `out_ready` to `out_valid`.
- `in_ready` depends only on the FSM state and `ce`; no combinational path from `in_valid`.
- `ce=0` in any state freezes the FSM and all outputs except `in_ready`, which is forced low.

## Configuration
- `MPC_DOT_ACC_ROUND_EN` defined: round half up. `2^(FRAC_SHIFT−1)` is added before the arithmetic shift.
- Not defined: truncation toward −∞ (plain arithmetic shift).
- Saturation, latency and the handshake are identical in both builds.

## Structure
- Package `mpc_dot_pkg` holds:
  - the FSM state enum `dot_state_t` (ACC, SCALE, HOLD);
  - default width constants;
  - function `sat_signed(value, width)`.
- Sub-module `mpc_dot_acc_scale`: combinational round/shift/saturate. Takes the ACC_WIDTH sum and returns DOUT_WIDTH plus a saturation bit. Its output is registered by the parent in SCALE.

## Test plan
All cases use the default parameters.
1. Single beat, `din=409600`, `in_last=1` → `out_valid` 2 cycles later, `dout=100`, `out_sat=0`, `in_ready` high 3 cycles after the beat.
2. Beats 2048, 2048, 4096 (last) → `dout=2`. Rounding check, single-beat rows:
   - `din=2048` → `dout=1` with ROUND_EN, `0` without;
   - `din=−2048` → `0` with ROUND_EN, `−1` without.
3. Saturation:
   - `din=2^34−1` → `dout=1048575`, `out_sat=1`;
   - `din=−2^34` → `dout=−1048576`, `out_sat=1`.
4. Backpressure: hold `out_ready=0` for 5 cycles after `out_valid`.
   - During the stall, `dout` is stable and `in_ready=0`.
   - Raise `out_ready` → one transfer, then `in_ready=1` the next cycle.
   - Toggle `ce=0` mid-row → no beats are lost or duplicated.
5. 129 beats of `din=1`, last on the 130th:
   - `err_ovf` rises on the 129th acceptance and stays high;
   - `dout=0` (130 ≫ 12 = 0; with rounding, 130 + 2048 ≫ 12 = 0).
6. Reset low for one cycle after 3 accepted beats of 4096:
   - all outputs return to their reset values;
   - a following 1-beat row of `din=8192` gives `dout=2`.
